// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN accelerator upsampling path.
//   MODE_24 / MODE_8 : encodings of the upsampler mode select
//   IW_24 / IW_8     : input row width (and height) for each mode
//   fsm_t            : upsampler FSM states (FILL, REPLAY)
//   mode_width()     : maps a mode select to its input width
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam logic MODE_24 = 1'b0;
    localparam logic MODE_8  = 1'b1;

    localparam int IW_24 = 12;
    localparam int IW_8  = 4;

    typedef enum logic {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } fsm_t;

    // Input maps are square, so this is both the row width and the row count.
    function automatic int unsigned mode_width(input logic mode);
        return (mode == MODE_8) ? IW_8 : IW_24;
    endfunction

endpackage

// File: rtl/line_buffer_1r1w.sv
// -----------------------------------------------------------------------------
// line_buffer_1r1w
// One-row pixel store: DEPTH x DW register array, one synchronous write port
// and one asynchronous read port. A write to the address being read is
// forwarded straight onto the read data. Contents are not reset.
// Ports:
//   clk      in   clock, rising edge
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_raddr  in   read address
//   o_rdata  out  read data (combinational)
// -----------------------------------------------------------------------------
module line_buffer_1r1w #(
    parameter int DW    = 8,
    parameter int DEPTH = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];

endmodule

// File: rtl/upsample_2x2.sv
// -----------------------------------------------------------------------------
// upsample_2x2
// 2x2 nearest-neighbour upsampler. Consumes a row-major stream of pooled
// pixels (12x12 or 4x4) and emits the 2x expanded map (24x24 or 8x8).
// Each input row is emitted twice: first interleaved with the incoming
// pixels (FILL, which also stores the row), then replayed from the line
// buffer (REPLAY).
// Optional build macro:
//   UPSAMPLE_ZERO_FILL_EN : zero-insertion variant; every non-original output
//                           position is 0 and no line buffer is built.
// Ports:
//   clk     in   clock, rising edge
//   rstn    in   asynchronous active-low reset
//   state   in   mode select (0: 12x12 -> 24x24, 1: 4x4 -> 8x8), sampled at frame start
//   ivalid  in   input pixel valid
//   iready  out  input accept
//   din     in   input pixel
//   ovalid  out  output pixel valid (registered)
//   oready  in   downstream accept
//   dout    out  output pixel (registered)
//   oeol    out  last pixel of an output row
//   oeof    out  last pixel of an output frame
// -----------------------------------------------------------------------------
module upsample_2x2 import cnn_pkg::*; #(
    parameter int DW   = 8,
    parameter int MAXW = 12
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          state,
    input  logic          ivalid,
    output logic          iready,
    input  logic [DW-1:0] din,
    output logic          ovalid,
    input  logic          oready,
    output logic [DW-1:0] dout,
    output logic          oeol,
    output logic          oeof
);

    localparam int CW = $clog2(MAXW);

    fsm_t          r_fsm,    w_fsm_next;
    logic [CW-1:0] r_col,    w_col_next;
    logic [CW-1:0] r_row,    w_row_next;
    logic          r_dup,    w_dup_next;
    logic          r_mode,   w_mode_next;
    logic          r_ovalid, w_ovalid_next;
    logic [DW-1:0] r_dout,   w_dout_next;
    logic          r_oeol,   w_oeol_next;
    logic          r_oeof,   w_oeof_next;
    logic          r_run;

    logic          w_slot_free;
    logic          w_xfer;
    logic          w_frame_start;
    logic          w_last_col;
    logic          w_last_row;
    logic [CW-1:0] w_iw_m1;
    logic [DW-1:0] w_line_rd;

    // Maps are square: the same limit bounds both col and row.
    assign w_iw_m1       = CW'(mode_width(r_mode) - 1);
    assign w_last_col    = (r_col == w_iw_m1);
    assign w_last_row    = (r_row == w_iw_m1);
    assign w_slot_free   = !r_ovalid || oready;
    assign w_frame_start = (r_fsm == FILL) && (r_row == '0) && (r_col == '0) && !r_dup;

    // r_run keeps iready low until the first edge after reset release.
    assign iready = r_run && (r_fsm == FILL) && !r_dup && w_slot_free;
    assign w_xfer = ivalid && iready;

`ifndef UPSAMPLE_ZERO_FILL_EN
    line_buffer_1r1w #(
        .DW    (DW),
        .DEPTH (MAXW),
        .AW    (CW)
    ) u_line_buffer (
        .clk     (clk),
        .i_we    (w_xfer),
        .i_waddr (r_col),
        .i_wdata (din),
        .i_raddr (r_col),
        .o_rdata (w_line_rd)
    );
`else
    // Zero insertion: every replayed/duplicate position carries 0.
    assign w_line_rd = '0;
`endif

    always_comb begin
        w_fsm_next    = r_fsm;
        w_col_next    = r_col;
        w_row_next    = r_row;
        w_dup_next    = r_dup;
        w_mode_next   = r_mode;
        w_ovalid_next = r_ovalid;
        w_dout_next   = r_dout;
        w_oeol_next   = r_oeol;
        w_oeof_next   = r_oeof;

        // Nothing moves while the output register holds an unaccepted pixel.
        if (w_slot_free) begin
            if (w_frame_start) begin
                w_mode_next = state;
            end

            unique case (r_fsm)
                FILL: begin
                    if (!r_dup) begin
                        if (w_xfer) begin
                            w_dout_next   = din;
                            w_ovalid_next = 1'b1;
                            w_dup_next    = 1'b1;
                            w_oeol_next   = 1'b0;
                            w_oeof_next   = 1'b0;
                        end else begin
                            w_ovalid_next = 1'b0;
                        end
                    end else begin
                        // Horizontal duplicate of the pixel just accepted.
                        w_dout_next   = w_line_rd;
                        w_ovalid_next = 1'b1;
                        w_dup_next    = 1'b0;
                        w_oeof_next   = 1'b0;
                        if (w_last_col) begin
                            w_oeol_next = 1'b1;
                            w_col_next  = '0;
                            w_fsm_next  = REPLAY;
                        end else begin
                            w_oeol_next = 1'b0;
                            w_col_next  = r_col + 1'b1;
                        end
                    end
                end
                REPLAY: begin
                    // Vertical duplicate: whole stored row, each pixel twice.
                    w_dout_next   = w_line_rd;
                    w_ovalid_next = 1'b1;
                    w_dup_next    = !r_dup;
                    w_oeol_next   = 1'b0;
                    w_oeof_next   = 1'b0;
                    if (r_dup) begin
                        if (w_last_col) begin
                            w_col_next  = '0;
                            w_oeol_next = 1'b1;
                            w_fsm_next  = FILL;
                            if (w_last_row) begin
                                w_oeof_next = 1'b1;
                                w_row_next  = '0;
                            end else begin
                                w_row_next  = r_row + 1'b1;
                            end
                        end else begin
                            w_col_next = r_col + 1'b1;
                        end
                    end
                end
                default: begin
                    w_fsm_next = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fsm    <= FILL;
            r_col    <= '0;
            r_row    <= '0;
            r_dup    <= 1'b0;
            r_mode   <= MODE_24;
            r_ovalid <= 1'b0;
            r_dout   <= '0;
            r_oeol   <= 1'b0;
            r_oeof   <= 1'b0;
            r_run    <= 1'b0;
        end else begin
            r_fsm    <= w_fsm_next;
            r_col    <= w_col_next;
            r_row    <= w_row_next;
            r_dup    <= w_dup_next;
            r_mode   <= w_mode_next;
            r_ovalid <= w_ovalid_next;
            r_dout   <= w_dout_next;
            r_oeol   <= w_oeol_next;
            r_oeof   <= w_oeof_next;
            r_run    <= 1'b1;
        end
    end

    assign ovalid = r_ovalid;
    assign dout   = r_dout;
    assign oeol   = r_oeol;
    assign oeof   = r_oeof;

endmodule

// File: tb/tb_upsample_2x2.sv
// -----------------------------------------------------------------------------
// tb_upsample_2x2
// Self-checking bench for upsample_2x2. Input frames are queued together with
// the expected expanded frame; outputs are popped and compared as accepted.
// Build with UPSAMPLE_ZERO_FILL_EN defined to check the zero-insertion variant.
// -----------------------------------------------------------------------------
module tb_upsample_2x2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       state;
    logic       ivalid;
    logic       iready;
    logic [7:0] din;
    logic       ovalid;
    logic       oready;
    logic [7:0] dout;
    logic       oeol;
    logic       oeof;

    upsample_2x2 #(.DW(8), .MAXW(12)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .state  (state),
        .ivalid (ivalid),
        .iready (iready),
        .din    (din),
        .ovalid (ovalid),
        .oready (oready),
        .dout   (dout),
        .oeol   (oeol),
        .oeof   (oeof)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int out_cnt, first_in_cyc, first_out_cyc, last_out_cyc;

    logic [7:0] in_q[$];
    logic [9:0] exp_q[$];   // {eof, eol, pixel}

    // Queue one input frame and its expected 2x expansion.
    task automatic push_frame(input logic m, input int base);
        int w;
        int v;
        logic eol, eof;
        w = m ? 4 : 12;
        for (int i = 0; i < w * w; i++) in_q.push_back(8'((base + i) & 255));
        for (int r2 = 0; r2 < 2 * w; r2++) begin
            for (int c2 = 0; c2 < 2 * w; c2++) begin
                v = (base + (r2 / 2) * w + (c2 / 2)) & 255;
`ifdef UPSAMPLE_ZERO_FILL_EN
                if ((r2 % 2) != 0 || (c2 % 2) != 0) v = 0;
`endif
                eol = (c2 == 2 * w - 1);
                eof = eol && (r2 == 2 * w - 1);
                exp_q.push_back({eof, eol, 8'(v)});
            end
        end
    endtask

    // Drive queued inputs and score outputs. bp: oready pattern 1,0,0,1;
    // gap: random ivalid holes; flip_at: toggle state after that many inputs;
    // stop_after: return once that many outputs have been accepted.
    task automatic run_stream(input string name, input int bp, input int gap,
                              input int flip_at, input int stop_after);
        int         in_acc = 0;
        int         budget = 0;
        logic       prev_stall = 1'b0;
        logic       do_flip = 1'b0;
        logic [9:0] prev_o = '0;
        logic [9:0] e;
        out_cnt = 0; first_in_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
        while (in_q.size() > 0 || exp_q.size() > 0) begin
            @(negedge clk);
            if (do_flip) begin state = ~state; do_flip = 1'b0; end
            oready = (bp == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            ivalid = (in_q.size() > 0) && (gap == 0 || $urandom_range(0, 2) != 0);
            din    = (in_q.size() > 0) ? in_q[0] : 8'h00;
            #1;
            if (prev_stall) begin
                checks++;
                if (ovalid !== 1'b1 || {oeof, oeol, dout} !== prev_o) begin
                    errors++;
                    $display("FAIL %s stall_hold cyc=%0d: got v=%b %h required v=1 %h",
                             name, cyc, ovalid, {oeof, oeol, dout}, prev_o);
                end
            end
            prev_stall = ovalid && !oready;
            prev_o     = {oeof, oeol, dout};
            if (ovalid && oready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_output: got d=%0d required no output", name, dout);
                end else begin
                    e = exp_q.pop_front();
                    if ({oeof, oeol, dout} !== e) begin
                        errors++;
                        $display("FAIL %s out[%0d]: got eof=%b eol=%b d=%0d required eof=%b eol=%b d=%0d",
                                 name, out_cnt, oeof, oeol, dout, e[9], e[8], e[7:0]);
                    end
                end
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                out_cnt++;
            end
            if (ivalid && iready) begin
                void'(in_q.pop_front());
                in_acc++;
                if (first_in_cyc < 0) first_in_cyc = cyc;
                if (in_acc == flip_at) do_flip = 1'b1;
            end
            cyc++;
            budget++;
            if (stop_after > 0 && out_cnt == stop_after) return;
            if (budget > 20000) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: got %0d outputs, %0d pending required 0 pending",
                         name, out_cnt, exp_q.size());
                in_q.delete();
                exp_q.delete();
                return;
            end
        end
        ivalid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; state = 1'b1; ivalid = 1'b0; oready = 1'b1; din = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({ovalid, oeol, oeof, iready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got v/eol/eof/ir=%b required 0000", {ovalid, oeol, oeof, iready});
        end
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout: got %h required 00", dout);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (iready !== 1'b0) begin
            errors++;
            $display("FAIL reset_iready_release: got %b required 0", iready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (iready !== 1'b1) begin
            errors++;
            $display("FAIL reset_iready_after_edge: got %b required 1", iready);
        end
    endtask

    task automatic test_4x4();
        state = 1'b1;
        push_frame(1'b1, 1);
        run_stream("4x4", 0, 0, -1, 0);
        checks++;
        if (out_cnt !== 64) begin
            errors++;
            $display("FAIL 4x4_count: got %0d required 64", out_cnt);
        end
        checks++;
        if (first_out_cyc !== first_in_cyc + 1) begin
            errors++;
            $display("FAIL 4x4_latency: got %0d required %0d", first_out_cyc - first_in_cyc, 1);
        end
        checks++;
        if (last_out_cyc - first_out_cyc !== 63) begin
            errors++;
            $display("FAIL 4x4_rate: got span %0d required 63", last_out_cyc - first_out_cyc);
        end
    endtask

    task automatic test_12x12();
        state = 1'b0;
        push_frame(1'b0, 0);
        run_stream("12x12", 0, 0, -1, 0);
        checks++;
        if (out_cnt !== 576) begin
            errors++;
            $display("FAIL 12x12_count: got %0d required 576", out_cnt);
        end
        checks++;
        if (last_out_cyc - first_out_cyc !== 575) begin
            errors++;
            $display("FAIL 12x12_rate: got span %0d required 575", last_out_cyc - first_out_cyc);
        end
    endtask

    task automatic test_backpressure();
        state = 1'b1;
        push_frame(1'b1, 50);
        push_frame(1'b1, 200);
        run_stream("bp_4x4", 1, 1, -1, 0);
        checks++;
        if (out_cnt !== 128) begin
            errors++;
            $display("FAIL bp_4x4_count: got %0d required 128", out_cnt);
        end
        state = 1'b0;
        push_frame(1'b0, 9);
        run_stream("bp_12x12", 1, 1, -1, 0);
        checks++;
        if (out_cnt !== 576) begin
            errors++;
            $display("FAIL bp_12x12_count: got %0d required 576", out_cnt);
        end
    endtask

    task automatic test_mode_change();
        state = 1'b1;
        push_frame(1'b1, 1);
        push_frame(1'b0, 20);
        run_stream("mode_change", 0, 0, 5, 0);
        checks++;
        if (out_cnt !== 640) begin
            errors++;
            $display("FAIL mode_change_count: got %0d required 640", out_cnt);
        end
    endtask

    task automatic test_reset_mid();
        state = 1'b1;
        push_frame(1'b1, 1);
        run_stream("rst_mid_pre", 0, 0, -1, 30);
        rstn = 1'b0;
        #1;
        checks++;
        if ({ovalid, oeol, oeof, iready} !== 4'b0000 || dout !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_outputs: got v/eol/eof/ir=%b d=%h required 0000 d=00",
                     {ovalid, oeol, oeof, iready}, dout);
        end
        in_q.delete();
        exp_q.delete();
        ivalid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        push_frame(1'b1, 1);
        run_stream("rst_mid_post", 0, 0, -1, 0);
        checks++;
        if (out_cnt !== 64) begin
            errors++;
            $display("FAIL rst_mid_count: got %0d required 64", out_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_4x4();
        test_12x12();
        test_backpressure();
        test_mode_change();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/upsample_2x2.md
# upsample_2x2

Nearest-neighbour 2×2 upsampler (max-unpool inverse) for the CNN accelerator datapath. It accepts a row-major stream of pooled 8-bit feature-map pixels, 12×12 or 4×4 as selected by `state`. It emits the 2× expanded map, 24×24 or 8×8: each input pixel is repeated horizontally and each row vertically. The block sits on the decoder/upsampling side of the pooling stage. It uses a one-row line buffer, and its input and output handshakes are independent valid/ready pairs.

## Interface
- `DW`, 8, pixel width
- `MAXW`, 12, maximum input row width (line-buffer depth)
- `clk`  in  1  clock, rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `state`  in  1  mode select: 0 means 12×12 → 24×24; 1 means 4×4 → 8×8
- `ivalid`  in  1  input pixel valid
- `iready`  out  1  input accept; a transfer occurs when `ivalid && iready`
- `din`  in  DW  input pixel
- `ovalid`  out  1  output pixel valid (registered)
- `oready`  in  1  downstream accept
- `dout`  out  DW  output pixel (registered)
- `oeol`  out  1  qualifies the last pixel of an output row; valid with `ovalid`
- `oeof`  out  1  qualifies the last pixel of an output frame; valid with `ovalid`

## Operation
- Mode `IW` (input width) and `IH` (input height) are 12/12 for `state`=0 and 4/4 for `state`=1.
- `state` is latched into `mode_q` only at frame start, when the FSM is in FILL with `row`=0, `col`=0 and `dup`=0. Changes at any other time are ignored until the next frame.
- The output slot is free when `!ovalid || oready`. All register updates below happen only when the slot is free; otherwise every register holds.
- The FSM has two states, FILL and REPLAY. The counters are `col` (0..IW-1), `row` (0..IH-1) and `dup` (0/1).
- FILL, `dup`=0:
  - `iready` = slot free.
  - On transfer: `dout`←`din`, `line[col]`←`din`, `ovalid`←1, `dup`←1.
  - With no transfer: `ovalid`←0.
- FILL, `dup`=1:
  - `iready`=0.
  - `dout`←`line[col]`, `ovalid`←1, `dup`←0.
  - If `col`=IW-1: `oeol`←1, `col`←0, FSM→REPLAY. Otherwise `col`++.
- REPLAY:
  - `iready`=0.
  - `dout`←`line[col]`, `ovalid`←1, and `dup` toggles. `col` advances after `dup`=1.
  - On the final pixel (`col`=IW-1, `dup`=1): `oeol`←1, FSM→FILL.
  - If `row`=IH-1 at that point: `oeof`←1, `row`←0. Otherwise `row`++.
- `oeol` and `oeof` are registered with `dout` and cleared on any other load.
- Each frame produces 4·IW·IH outputs: 576 for `state`=0 and 64 for `state`=1.

## Timing
- Reset values: `ovalid`=0, `dout`=0, `oeol`=0, `oeof`=0, `iready`=0.
- Internal reset values: FSM=FILL, `col`/`row`/`dup`=0, `mode_q`=0.
- The line buffer is not reset.
- `iready` first asserts in the cycle after `rstn` is released.
- Latency: a pixel accepted at edge n appears on `dout` after edge n; its duplicate appears after edge n+1 if `oready` is held high.
- With `oready`=1 the output rate is 1 pixel/clk. Input is accepted at most every other cycle during FILL and never during REPLAY.
- `iready` depends combinationally on `oready`. There is no combinational path from `ivalid` to `iready`.
- While `ovalid && !oready`, `dout`, `oeol` and `oeof` must be held stable.
- If `ivalid` drops mid-row in FILL, `ovalid` deasserts after the pending duplicate. There is no bubble inside a duplicate pair.
- An asynchronous reset mid-frame drops all in-flight pixels. The next accepted pixel is treated as pixel (0,0).

## Configuration
- `UPSAMPLE_ZERO_FILL_EN` defined: zero-insertion upsampling.
  - Every duplicate position (FILL `dup`=1) and every REPLAY pixel outputs 0.
  - The line buffer is not instantiated.
  - Handshake, counters, `oeol` and `oeof` are unchanged.
- `UPSAMPLE_ZERO_FILL_EN` undefined: nearest-neighbour duplication as above.

## Structure
- Shared package `cnn_pkg` holds:
  - `MODE_24`=1'b0 and `MODE_8`=1'b1
  - the widths `IW_24`=12 and `IW_8`=4
  - the FSM state typedef (FILL, REPLAY)
- Sub-module `line_buffer_1r1w`: MAXW×DW register array with 1 write port and 1 asynchronous read port, with write data bypassed onto the read port. It is omitted under `UPSAMPLE_ZERO_FILL_EN`.

## Test plan
- **4×4 basic:** `state`=1, `ivalid`=1, `oready`=1, `din`=1..16.
  - Output is 64 pixels with rows 1,1,2,2,3,3,4,4 / 1,1,2,2,3,3,4,4 / 5,5,…
  - `oeol` on every 8th output; `oeof` only on the 64th.
- **12×12 basic:** `state`=0, `din`=0..143.
  - 576 outputs; row 2 equals row 1; `oeol` every 24.
  - Pixels 575 and 576 are 143, with `oeof` on 576.
- **Backpressure:** `oready` toggled 1,0,0,1 repeatedly.
  - `dout` holds while stalled; the output sequence is identical to the unstalled case.
  - No input is accepted while `iready`=0.
- **Mode change mid-frame:** `state` flipped 1→0 after 5 inputs.
  - The current frame completes as 8×8 (64 outputs); the next frame is 24×24.
- **Reset mid-frame:** `rstn` pulsed low after 30 outputs.
  - All outputs are 0 immediately; a fresh 4×4 frame then reproduces the basic 4×4 expected sequence.
- **Zero fill:** `UPSAMPLE_ZERO_FILL_EN` defined, 4×4 input 1..16.
  - Output rows are 1,0,2,0,3,0,4,0 / 0×8 / 5,0,6,0,…
